// File: rtl/ctx_kparam_ctrl.sv
// ctx_kparam_ctrl: context-statistics sequencer for a LOCO-I encoder.
// Per request it fetches {A,N} for the context and derives the Golomb parameter k
// with an iterative shift-compare. It then emits k and writes back the updated {A,N},
// halving both fields when N reaches RESET_TH. After rst it sweeps every context
// entry to {A_INIT,1}.
//
// Optional feature: define CTX_BYPASS_EN to forward the last written {A,N}. A request
// to the same context then skips the RAM read.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_ctx, req_err         context index, absolute prediction error
//   k_valid, k_out           one-cycle k pulse; k_out holds until the next pulse
//   ram_raddr, ram_rdata     context RAM read port (1-cycle latency), data {A,N}
//   ram_we, ram_waddr,
//   ram_wdata                context RAM write port, data {A,N}
module ctx_kparam_ctrl #(
  parameter int unsigned NUM_CTX  = 365,
  parameter int unsigned CTX_AW   = 9,
  parameter int unsigned A_W      = 13,
  parameter int unsigned N_W      = 7,
  parameter int unsigned RESET_TH = 64,
  parameter int unsigned A_INIT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CTX_AW-1:0]    req_ctx,
  input  logic [8:0]           req_err,
  output logic                 k_valid,
  output logic [3:0]           k_out,
  output logic [CTX_AW-1:0]    ram_raddr,
  input  logic [A_W+N_W-1:0]   ram_rdata,
  output logic                 ram_we,
  output logic [CTX_AW-1:0]    ram_waddr,
  output logic [A_W+N_W-1:0]   ram_wdata
);

  localparam int unsigned D_W   = A_W + N_W;
  localparam int unsigned CNT_W = CTX_AW + 1;
  localparam int unsigned ERR_W = 9;
  localparam int unsigned K_W   = 4;
  localparam int unsigned K_MAX = 13;
  localparam int unsigned SH_W  = 20;

  typedef enum logic [2:0] {INIT, IDLE, RD, LD, KC, WR} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   init_cnt, init_cnt_nx;
  logic [CTX_AW-1:0]  ctx_r, ctx_nx;
  logic [ERR_W-1:0]   err_r, err_nx;
  logic [A_W-1:0]     a_r, a_nx;
  logic [N_W-1:0]     n_r, n_nx;
  logic [K_W-1:0]     k_r, k_nx;

  logic               req_ready_nx;
  logic               k_valid_nx;
  logic [K_W-1:0]     k_out_nx;
  logic [CTX_AW-1:0]  ram_raddr_nx;
  logic               ram_we_nx;
  logic [CTX_AW-1:0]  ram_waddr_nx;
  logic [D_W-1:0]     ram_wdata_nx;

`ifdef CTX_BYPASS_EN
  logic [CTX_AW-1:0]  last_ctx, last_ctx_nx;
  logic               byp_vld, byp_vld_nx;
`endif

  logic [SH_W-1:0]    n_shift;
  logic               k_grow;
  logic [A_W:0]       a_sum;
  logic [A_W:0]       a_pre;
  logic [A_W-1:0]     a_wr;
  logic [N_W-1:0]     n_wr;

  // k search step and write-back value (halve at RESET_TH, then saturate A)
  always_comb begin
    n_shift = SH_W'(n_r) << k_r;
    k_grow  = (n_shift < SH_W'(a_r)) && (k_r < K_W'(K_MAX));
    a_sum   = {1'b0, a_r} + (A_W+1)'(err_r);
    if (n_r == N_W'(RESET_TH)) begin
      a_pre = a_sum >> 1;
      n_wr  = (n_r >> 1) + N_W'(1);
    end else begin
      a_pre = a_sum;
      n_wr  = n_r + N_W'(1);
    end
    a_wr = a_pre[A_W] ? {A_W{1'b1}} : a_pre[A_W-1:0];
  end

  // next-state and next-output logic; outputs are registered from *_nx
  always_comb begin
    state_nx     = state;
    init_cnt_nx  = init_cnt;
    ctx_nx       = ctx_r;
    err_nx       = err_r;
    a_nx         = a_r;
    n_nx         = n_r;
    k_nx         = k_r;
    k_valid_nx   = 1'b0;
    k_out_nx     = k_out;
    ram_raddr_nx = ram_raddr;
    ram_we_nx    = 1'b0;
    ram_waddr_nx = ram_waddr;
    ram_wdata_nx = ram_wdata;
`ifdef CTX_BYPASS_EN
    last_ctx_nx  = last_ctx;
    byp_vld_nx   = byp_vld;
`endif

    case (state)
      INIT: begin
        if (init_cnt == CNT_W'(NUM_CTX)) begin
          state_nx = IDLE;
        end else begin
          ram_we_nx    = 1'b1;
          ram_waddr_nx = init_cnt[CTX_AW-1:0];
          ram_wdata_nx = {A_W'(A_INIT), N_W'(1)};
          init_cnt_nx  = init_cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          ctx_nx = req_ctx;
          err_nx = req_err;
`ifdef CTX_BYPASS_EN
          if (byp_vld && (req_ctx == last_ctx)) begin
            k_nx     = '0;
            state_nx = KC;
          end else begin
            ram_raddr_nx = req_ctx;
            state_nx     = RD;
          end
`else
          ram_raddr_nx = req_ctx;
          state_nx     = RD;
`endif
        end
      end
      RD: state_nx = LD;
      LD: begin
        a_nx     = ram_rdata[D_W-1:N_W];
        n_nx     = ram_rdata[N_W-1:0];
        k_nx     = '0;
        state_nx = KC;
      end
      KC: begin
        if (k_grow) begin
          k_nx = k_r + K_W'(1);
        end else begin
          // outputs for the WR cycle are loaded on this edge
          k_valid_nx   = 1'b1;
          k_out_nx     = k_r;
          ram_we_nx    = 1'b1;
          ram_waddr_nx = ctx_r;
          ram_wdata_nx = {a_wr, n_wr};
          state_nx     = WR;
        end
      end
      WR: begin
`ifdef CTX_BYPASS_EN
        a_nx        = ram_wdata[D_W-1:N_W];
        n_nx        = ram_wdata[N_W-1:0];
        last_ctx_nx = ctx_r;
        byp_vld_nx  = 1'b1;
`endif
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase

    req_ready_nx = (state_nx == IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      ctx_r     <= '0;
      err_r     <= '0;
      a_r       <= '0;
      n_r       <= '0;
      k_r       <= '0;
      req_ready <= 1'b0;
      k_valid   <= 1'b0;
      k_out     <= '0;
      ram_raddr <= '0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
`ifdef CTX_BYPASS_EN
      last_ctx  <= '0;
      byp_vld   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      init_cnt  <= init_cnt_nx;
      ctx_r     <= ctx_nx;
      err_r     <= err_nx;
      a_r       <= a_nx;
      n_r       <= n_nx;
      k_r       <= k_nx;
      req_ready <= req_ready_nx;
      k_valid   <= k_valid_nx;
      k_out     <= k_out_nx;
      ram_raddr <= ram_raddr_nx;
      ram_we    <= ram_we_nx;
      ram_waddr <= ram_waddr_nx;
      ram_wdata <= ram_wdata_nx;
`ifdef CTX_BYPASS_EN
      last_ctx  <= last_ctx_nx;
      byp_vld   <= byp_vld_nx;
`endif
    end
  end

endmodule
